gcd_arbiter: RTL and testbench

Shares one subtraction-based GCD engine between NUM_REQ requesters.
- Round-robin arbitration over requesters, each using a valid/ready handshake.
- Sequences the iterative subtract loop itself.
- Returns result, requester ID, step count and error flag on a single valid/ready response port.
- Sits between the host-side request fabric and the GCD datapath in the number-theory helpers.

---
 rtl/gcd_arbiter_pkg.sv | 14 +
 rtl/gcd_rr_arbiter.sv | 35 +++
 rtl/gcd_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_gcd_arbiter.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_arbiter_pkg.sv
// Shared definitions for the GCD arbiter: FSM state encoding and default sizes.
package gcd_arbiter_pkg;

  localparam int unsigned DefaultWidth  = 4;
  localparam int unsigned DefaultNumReq = 4;
  localparam int unsigned DefaultIdW    = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } gcd_state_e;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus encoded index, searching
// upward from rr_ptr and wrapping modulo NUM_REQ.
module gcd_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  int unsigned      idx;
  logic [ID_W-1:0]  idx_b;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    idx_b       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx   = (32'(rr_ptr) + k) % NUM_REQ;
      idx_b = ID_W'(idx);
      // First hit from rr_ptr wins; later offsets are ignored once granted.
      if (!grant_valid && req_valid[idx_b]) begin
        grant_valid  = 1'b1;
        grant_idx    = idx_b;
        grant[idx_b] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one subtraction-based GCD engine among NUM_REQ requesters with
// round-robin arbitration and a single valid/ready response port.
module gcd_arbiter
  import gcd_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned NUM_REQ = DefaultNumReq,
  parameter int unsigned ID_W    = DefaultIdW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_gcd,
  output logic [WIDTH-1:0]         resp_iters,
  output logic                     resp_err,
  output logic                     busy
);

  gcd_state_e       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic             err_q, err_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_valid;
  logic [WIDTH-1:0]   sel_x, sel_y;
  logic               accept;
  logic               zero_op;

  gcd_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_valid   (req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Operand mux for the granted requester.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_x = req_x[i*WIDTH +: WIDTH];
        sel_y = req_y[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept  = (state_q == StIdle) && grant_valid;
  assign zero_op = (sel_x == '0) || (sel_y == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = zero_op ? StDone : StRun;
        end
      end
      StRun: begin
        if (a_q == b_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      steps_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      steps_q  <= steps_d;
      err_q    <= err_d;
    end
  end

  // Accept latch and subtract loop
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    steps_d  = steps_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          id_d     = grant_idx;
          steps_d  = '0;
          rr_ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
          if (zero_op) begin
            // With one operand zero the OR is the other operand; both zero gives 0.
            a_d   = sel_x | sel_y;
            b_d   = sel_x | sel_y;
            err_d = (sel_x == '0) && (sel_y == '0);
          end else begin
            a_d   = sel_x;
            b_d   = sel_y;
            err_d = 1'b0;
          end
        end
      end
      StRun: begin
        if (a_q > b_q) begin
          a_d     = a_q - b_q;
          steps_d = steps_q + WIDTH'(1);
        end else if (b_q > a_q) begin
          b_d     = b_q - a_q;
          steps_d = steps_q + WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs; req_ready is gated by reset so it stays low while reset is held.
  always_comb begin
    req_ready  = '0;
    resp_valid = 1'b0;
    resp_id    = '0;
    resp_gcd   = '0;
    resp_iters = '0;
    resp_err   = 1'b0;
    busy       = 1'b0;
    case (state_q)
      StIdle: begin
        if (reset) begin
          req_ready = grant;
        end
      end
      StRun: begin
        busy = 1'b1;
      end
      StDone: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        resp_id    = id_q;
        resp_gcd   = a_q;
        resp_iters = steps_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter: expected responses are queued at accept
// time and compared when the response port presents them.
module tb_gcd_arbiter;

  localparam int WIDTH   = 4;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] gcd;
    logic [WIDTH-1:0] iters;
    logic             err;
  } resp_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_x;
  logic [NUM_REQ*WIDTH-1:0] req_y;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [WIDTH-1:0]         resp_gcd;
  logic [WIDTH-1:0]         resp_iters;
  logic                     resp_err;
  logic                     busy;

  resp_t sb[$];
  int    checks = 0;
  int    errors = 0;

  gcd_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_gcd   (resp_gcd),
    .resp_iters (resp_iters),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference: Euclid by remainder for the gcd, subtraction count for the steps.
  function automatic resp_t model(int id, int x, int y);
    resp_t r;
    int    a, b, n;
    r.id  = ID_W'(id);
    r.err = (x == 0) && (y == 0);
    a = x;
    b = y;
    while (b != 0) begin
      n = a % b;
      a = b;
      b = n;
    end
    r.gcd = WIDTH'(a);
    n = 0;
    if (x != 0 && y != 0) begin
      a = x;
      b = y;
      while (a != b) begin
        if (a > b) a = a - b;
        else       b = b - a;
        n++;
      end
    end
    r.iters = WIDTH'(n);
    return r;
  endfunction

  function automatic int exp_lat(int x, int y);
    resp_t r;
    r = model(0, x, y);
    // Zero-operand jobs reach DONE on the accept edge itself.
    return (x == 0 || y == 0) ? 0 : int'(r.iters) + 1;
  endfunction

  function automatic string fmt(resp_t r);
    return $sformatf("id=%0d gcd=%0d iters=%0d err=%0d", r.id, r.gcd, r.iters, r.err);
  endfunction

  function automatic resp_t cur_resp();
    return {resp_id, resp_gcd, resp_iters, resp_err};
  endfunction

  task automatic set_req(int i, int x, int y);
    logic [NUM_REQ*WIDTH-1:0] m;
    m = {{((NUM_REQ-1)*WIDTH){1'b0}}, {WIDTH{1'b1}}} << (i*WIDTH);
    req_x = (req_x & ~m) | (((NUM_REQ*WIDTH)'(x)) << (i*WIDTH) & m);
    req_y = (req_y & ~m) | (((NUM_REQ*WIDTH)'(y)) << (i*WIDTH) & m);
    req_valid = req_valid | (NUM_REQ'(1) << i);
  endtask

  // Holds reset for two edges and releases it just after a rising edge.
  task automatic do_reset();
    reset      = 1'b0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic accept_one(output int idx, output logic [NUM_REQ-1:0] seen, output bit ok);
    ok   = 1'b0;
    idx  = 0;
    seen = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        seen = req_ready;
        ok   = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) idx = i;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1 req_valid = req_valid & ~(NUM_REQ'(1) << idx);
    end
  endtask

  // Counts rising edges after the accept edge until resp_valid is seen.
  task automatic wait_resp(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    resp_ready = 1'b1;
    req_valid  = '1;
    req_x      = 16'h5a3c;
    req_y      = 16'hc3a5;
    #12;
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_gcd, resp_iters, resp_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b busy=%b, want all 0",
               req_ready, resp_valid, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_gcd, resp_iters, resp_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got ready=%b valid=%b busy=%b, want all 0",
               req_ready, resp_valid, busy);
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    int idx, lat;
    bit ok;
    logic [NUM_REQ-1:0] seen;
    resp_t exp;
    do_reset();
    set_req(0, 12, 15);
    accept_one(idx, seen, ok);
    checks++;
    if (!ok || seen !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: got ok=%0d ready=%b, want ok=1 ready=0001", ok, seen);
    end
    if (ok) sb.push_back({2'd0, 4'd3, 4'd4, 1'b0});
    wait_resp(lat, ok);
    checks++;
    if (!ok || lat != 5) begin
      errors++;
      $display("FAIL single_latency: got ok=%0d lat=%0d, want ok=1 lat=5", ok, lat);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : resp_t'('1);
    checks++;
    if (cur_resp() !== exp) begin
      errors++;
      $display("FAIL single_resp: got %s, want %s", fmt(cur_resp()), fmt(exp));
    end
    @(posedge clk);
    #1;
    checks++;
    if ({busy, resp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: got busy=%b valid=%b, want 0 0", busy, resp_valid);
    end
  endtask

  task automatic test_zero();
    int xs[3] = '{0, 0, 7};
    int ys[3] = '{9, 0, 0};
    int idx, lat;
    bit ok;
    logic [NUM_REQ-1:0] seen;
    resp_t exp;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_req(1, xs[k], ys[k]);
      accept_one(idx, seen, ok);
      checks++;
      if (!ok || idx != 1) begin
        errors++;
        $display("FAIL zero_grant%0d: got ok=%0d idx=%0d, want ok=1 idx=1", k, ok, idx);
      end
      if (ok) sb.push_back(model(idx, xs[k], ys[k]));
      wait_resp(lat, ok);
      checks++;
      if (!ok || lat != exp_lat(xs[k], ys[k])) begin
        errors++;
        $display("FAIL zero_latency%0d: got ok=%0d lat=%0d, want ok=1 lat=%0d",
                 k, ok, lat, exp_lat(xs[k], ys[k]));
      end
      exp = (sb.size() > 0) ? sb.pop_front() : resp_t'('1);
      checks++;
      if (cur_resp() !== exp) begin
        errors++;
        $display("FAIL zero_resp%0d: got %s, want %s", k, fmt(cur_resp()), fmt(exp));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_fairness();
    int xs[4] = '{8, 7, 9, 5};
    int ys[4] = '{12, 7, 6, 3};
    int order[6] = '{0, 1, 2, 3, 0, 2};
    int idx, lat;
    bit ok;
    logic [NUM_REQ-1:0] seen;
    resp_t exp;
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, xs[i], ys[i]);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        set_req(0, xs[0], ys[0]);
        set_req(2, xs[2], ys[2]);
      end
      accept_one(idx, seen, ok);
      checks++;
      if (!ok || idx != order[k]) begin
        errors++;
        $display("FAIL fair_order%0d: got ok=%0d idx=%0d, want ok=1 idx=%0d",
                 k, ok, idx, order[k]);
      end
      if (ok) sb.push_back(model(idx, xs[idx], ys[idx]));
      wait_resp(lat, ok);
      checks++;
      if (!ok || lat != exp_lat(xs[order[k]], ys[order[k]])) begin
        errors++;
        $display("FAIL fair_latency%0d: got ok=%0d lat=%0d, want ok=1 lat=%0d",
                 k, ok, lat, exp_lat(xs[order[k]], ys[order[k]]));
      end
      exp = (sb.size() > 0) ? sb.pop_front() : resp_t'('1);
      checks++;
      if (cur_resp() !== exp) begin
        errors++;
        $display("FAIL fair_resp%0d: got %s, want %s", k, fmt(cur_resp()), fmt(exp));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    int idx, lat;
    bit ok;
    logic [NUM_REQ-1:0] seen;
    resp_t exp, snap;
    do_reset();
    set_req(3, 9, 6);
    accept_one(idx, seen, ok);
    if (ok) sb.push_back(model(idx, 9, 6));
    resp_ready = 1'b0;
    wait_resp(lat, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_valid: got no response, want resp_valid");
    end
    snap = cur_resp();
    exp  = (sb.size() > 0) ? sb.pop_front() : resp_t'('1);
    checks++;
    if (snap !== exp) begin
      errors++;
      $display("FAIL bp_resp: got %s, want %s", fmt(snap), fmt(exp));
    end
    set_req(0, 1, 1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({resp_valid, busy, req_ready} !== {2'b11, 4'b0000} || cur_resp() !== exp) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b busy=%b ready=%b %s, want 1 1 0000 %s",
                 c, resp_valid, busy, req_ready, fmt(cur_resp()), fmt(exp));
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, resp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL bp_release: got busy=%b valid=%b, want 0 0", busy, resp_valid);
    end
    accept_one(idx, seen, ok);
    if (ok) sb.push_back(model(idx, 1, 1));
    wait_resp(lat, ok);
    checks++;
    if (!ok || lat != 1) begin
      errors++;
      $display("FAIL bp_next_latency: got ok=%0d lat=%0d, want ok=1 lat=1", ok, lat);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : resp_t'('1);
    checks++;
    if (cur_resp() !== exp) begin
      errors++;
      $display("FAIL bp_next_resp: got %s, want %s", fmt(cur_resp()), fmt(exp));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_worst();
    int idx, lat;
    bit ok;
    logic [NUM_REQ-1:0] seen;
    resp_t exp;
    do_reset();
    set_req(2, 15, 1);
    accept_one(idx, seen, ok);
    if (ok) sb.push_back(model(idx, 15, 1));
    wait_resp(lat, ok);
    checks++;
    if (!ok || lat != 15) begin
      errors++;
      $display("FAIL worst_latency: got ok=%0d lat=%0d, want ok=1 lat=15", ok, lat);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : resp_t'('1);
    checks++;
    if (cur_resp() !== exp || resp_iters !== 4'd14) begin
      errors++;
      $display("FAIL worst_resp: got %s, want %s", fmt(cur_resp()), fmt(exp));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int idx, lat;
    bit ok;
    logic [NUM_REQ-1:0] seen;
    resp_t exp;
    do_reset();
    set_req(0, 15, 1);
    accept_one(idx, seen, ok);
    if (ok) sb.push_back(model(idx, 15, 1));
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy: got busy=%b, want 1", busy);
    end
    #1 reset = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_gcd, resp_iters, resp_err, busy} !== '0) begin
      errors++;
      $display("FAIL midrun_async: got ready=%b valid=%b busy=%b, want all 0",
               req_ready, resp_valid, busy);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    set_req(2, 6, 4);
    accept_one(idx, seen, ok);
    checks++;
    if (!ok || seen !== 4'b0100) begin
      errors++;
      $display("FAIL midrun_grant: got ok=%0d ready=%b, want ok=1 ready=0100", ok, seen);
    end
    if (ok) sb.push_back(model(idx, 6, 4));
    wait_resp(lat, ok);
    checks++;
    if (!ok || lat != 3) begin
      errors++;
      $display("FAIL midrun_latency: got ok=%0d lat=%0d, want ok=1 lat=3", ok, lat);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : resp_t'('1);
    checks++;
    if (cur_resp() !== exp) begin
      errors++;
      $display("FAIL midrun_resp: got %s, want %s", fmt(cur_resp()), fmt(exp));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_valid  = '0;
    req_x      = '0;
    req_y      = '0;
    resp_ready = 1'b1;
    reset      = 1'b0;
    test_reset();
    test_single();
    test_zero();
    test_fairness();
    test_backpressure();
    test_worst();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
